// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding buffer.
//   Frame: start bit (0), 8 data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT clocks.
//   A byte can be accepted while the previous frame is still shifting out,
//   so back-to-back frames leave no idle gap on the line.
// Ports:
//   clk      system clock, rising edge
//   rstN     asynchronous active-low reset
//   txStart  byte-valid strobe; accepted when txReady=1
//   txIn     byte to send, sampled on accept
//   txReady  holding buffer empty
//   tx       serial line, registered, idles high
//   txBusy   a frame is in progress
//   txDone   one-cycle pulse in the last cycle of the final stop bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txReady,
  output logic       tx,
  output logic       txBusy,
  output logic       txDone
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baudCnt;
  logic [2:0]       bitIdx;
  logic             stopCnt;
  logic             bufFull;
  logic [7:0]       bufData;
  logic [7:0]       shiftReg;
  logic             parityBit;

  logic bitEnd;
  logic lastStop;
  logic load;
  logic accept;

  assign bitEnd   = (baudCnt == CNT_LAST);
  assign lastStop = (state == STOP) && bitEnd && (stopCnt == STOP_LAST);
  // A full buffer is launched either from idle or straight out of the final
  // stop bit, which is what gives zero-gap back-to-back frames.
  assign load     = bufFull && ((state == IDLE) || lastStop);
  assign accept   = txStart && !bufFull;

  assign txReady  = !bufFull;
  assign txBusy   = (state != IDLE);

  // Control: FSM, baud counter, buffer flag and line outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      tx      <= 1'b1;
      txDone  <= 1'b0;
      bufFull <= 1'b0;
      baudCnt <= '0;
      bitIdx  <= '0;
      stopCnt <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lines up with the last
      // counter value of the final stop bit.
      txDone <= (state == STOP) && (stopCnt == STOP_LAST) && (baudCnt == CNT_PRE);

      // accept needs an empty buffer and load needs a full one, so the two
      // never collide on the flag; the data path handles both on one edge.
      if (accept)    bufFull <= 1'b1;
      else if (load) bufFull <= 1'b0;

      if ((state == IDLE) || bitEnd) baudCnt <= '0;
      else                           baudCnt <= baudCnt + 1'b1;

      if (load) begin
        state <= START;
        tx    <= 1'b0;
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            if (bitEnd) begin
              state  <= DATA;
              bitIdx <= '0;
              tx     <= shiftReg[0];
            end
          end
          DATA: begin
            if (bitEnd) begin
              if (bitIdx == 3'd7) begin
                if (PARITY_EN != 0) begin
                  state <= PARITY;
                  tx    <= parityBit;
                end else begin
                  state   <= STOP;
                  stopCnt <= 1'b0;
                  tx      <= 1'b1;
                end
              end else begin
                bitIdx <= bitIdx + 3'd1;
                // shiftReg shifts on this same edge, so bit 1 is the next bit
                tx     <= shiftReg[1];
              end
            end
          end
          PARITY: begin
            if (bitEnd) begin
              state   <= STOP;
              stopCnt <= 1'b0;
              tx      <= 1'b1;
            end
          end
          STOP: begin
            if (bitEnd) begin
              if (stopCnt == STOP_LAST) begin
                state <= IDLE;
                tx    <= 1'b1;
              end else begin
                stopCnt <= stopCnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Data path: holding buffer, shift register and parity (no reset needed,
  // contents are only used after a load that follows a fresh accept).
  always_ff @(posedge clk) begin
    if (accept) bufData <= txIn;
    if (load) begin
      shiftReg  <= bufData;
      parityBit <= (^bufData) ^ ODD;
    end else if ((state == DATA) && bitEnd) begin
      shiftReg <= {1'b0, shiftReg[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
//   Four instances: u0 8N1, u1 even parity, u2 odd parity, u3 two stop bits,
//   all at 16 clocks per bit. Stimulus pushes expected frames into per-unit
//   queues; a monitor per unit decodes the line and compares.
module tb_uart_tx;

  localparam int BIT_CLKS = 16;

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         b2b;
    bit         abort;
  } exp_t;

  logic       clk;
  logic       rstN;
  logic [3:0] startV;
  logic [7:0] inV [4];
  logic [3:0] readyV;
  logic [3:0] txV;
  logic [3:0] busyV;
  logic [3:0] doneV;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];

  for (genvar g = 0; g < 4; g++) begin : gDut
    uart_tx #(
      .CLKS_PER_BIT(BIT_CLKS),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) dut (
      .clk    (clk),
      .rstN   (rstN),
      .txStart(startV[g]),
      .txIn   (inV[g]),
      .txReady(readyV[g]),
      .tx     (txV[g]),
      .txBusy (busyV[g]),
      .txDone (doneV[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int idx, input logic [7:0] d, input logic p, input bit b2b, input bit ab);
    exp_t e;
    e.data = d; e.par = p; e.b2b = b2b; e.abort = ab;
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic popExp(input int idx, output exp_t e, output bit got);
    got = 1'b0;
    e.data = 8'h00; e.par = 1'b0; e.b2b = 1'b0; e.abort = 1'b0;
    case (idx)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
    endcase
  endtask

  // Decodes one unit's line, sampling on the falling edge.
  task automatic monitor(input int idx);
    exp_t e;
    bit   got;
    bit   aborted;
    logic expBits [14];
    bit   bad [14];
    int   nb, pe, stops, doneCnt, doneAt, bitsDone, startCyc;
    int   lastEnd = -100;
    forever begin
      @(negedge clk);
      if (rstN && txV[idx] === 1'b0) begin
        startCyc = cyc;
        popExp(idx, e, got);
        chk($sformatf("u%0d_frame_expected", idx), 32'(got), 32'd1);
        if (e.b2b) chk($sformatf("u%0d_b2b_start", idx), startCyc, lastEnd + 1);
        pe    = (idx == 1 || idx == 2) ? 1 : 0;
        stops = (idx == 3) ? 2 : 1;
        nb    = 9 + pe + stops;
        for (int i = 0; i < 14; i++) begin expBits[i] = 1'b1; bad[i] = 1'b0; end
        expBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) expBits[i+1] = e.data[i];
        if (pe != 0) expBits[9] = e.par;
        doneCnt = 0; doneAt = -1; aborted = 1'b0; bitsDone = 0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < BIT_CLKS; c++) begin
            if (!aborted) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!rstN) aborted = 1'b1;
              else begin
                if (txV[idx] !== expBits[b]) bad[b] = 1'b1;
                if (doneV[idx] === 1'b1) begin doneCnt++; doneAt = b * BIT_CLKS + c; end
              end
            end
          end
          if (!aborted) bitsDone = b + 1;
        end
        for (int b = 0; b < bitsDone; b++)
          chk($sformatf("u%0d_byte%02h_bit%0d_wrong", idx, e.data, b), 32'(bad[b]), 32'd0);
        chk($sformatf("u%0d_frame_aborted", idx), 32'(aborted), 32'(e.abort));
        if (!aborted) begin
          chk($sformatf("u%0d_done_count", idx), doneCnt, 32'd1);
          chk($sformatf("u%0d_done_pos", idx), doneAt, nb * BIT_CLKS - 1);
        end
        lastEnd = cyc;
      end
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
    monitor(2);
    monitor(3);
  join_none

  task automatic send(input int idx, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!readyV[idx] && n < 500) begin @(negedge clk); n++; end
    chk($sformatf("u%0d_ready_wait", idx), 32'(readyV[idx]), 32'd1);
    startV[idx] = 1'b1;
    inV[idx]    = d;
    @(posedge clk);
    #1 startV[idx] = 1'b0;
  endtask

  task automatic waitIdle(input int idx);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busyV[idx] && n < 2000) begin @(negedge clk); n++; end
    chk($sformatf("u%0d_idle_reached", idx), 32'(busyV[idx]), 32'd0);
  endtask

  initial begin
    int  n, readyLow, doneCnt;
    bit  quiet;
    rstN   = 1'b0;
    startV = '0;
    for (int i = 0; i < 4; i++) inV[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(txV), 32'hF);
    chk("reset_ready", 32'(readyV), 32'hF);
    chk("reset_busy", 32'(busyV), 32'h0);
    chk("reset_done", 32'(doneV), 32'h0);
    #2 rstN = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5, 8N1
    pushExp(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    send(0, 8'hA5);
    chk("t1_ready_after_accept", 32'(readyV[0]), 32'd0);
    chk("t1_busy_before_load", 32'(busyV[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_ready_after_load", 32'(readyV[0]), 32'd1);
    chk("t1_busy_after_load", 32'(busyV[0]), 32'd1);
    chk("t1_tx_start_bit", 32'(txV[0]), 32'd0);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (doneV[0]) break;
    end
    chk("t1_done_cycle", n, 32'd160);
    @(posedge clk);
    #1 chk("t1_busy_after_done", 32'(busyV[0]), 32'd0);

    // back-to-back 0x55 then 0x0F
    pushExp(0, 8'h55, 1'b0, 1'b0, 1'b0);
    pushExp(0, 8'h0F, 1'b0, 1'b1, 1'b0);
    send(0, 8'h55);
    send(0, 8'h0F);
    chk("t2_ready_low_after_accept", 32'(readyV[0]), 32'd0);
    readyLow = -1; doneCnt = 0; n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (readyV[0] && readyLow < 0) readyLow = n - 1;
      if (doneV[0]) doneCnt++;
      if (!busyV[0]) break;
    end
    chk("t2_ready_low_cycles", readyLow, 32'd159);
    chk("t2_done_pulses", doneCnt, 32'd2);

    // overflow: 0x11 offered while buffer holds 0x22
    pushExp(0, 8'h33, 1'b0, 1'b0, 1'b0);
    pushExp(0, 8'h22, 1'b0, 1'b1, 1'b0);
    send(0, 8'h33);
    send(0, 8'h22);
    @(negedge clk);
    startV[0] = 1'b1;
    inV[0]    = 8'h11;
    @(posedge clk);
    #1 startV[0] = 1'b0;
    chk("t3_ready_stays_low", 32'(readyV[0]), 32'd0);
    waitIdle(0);

    // parity: 0x07 has three ones
    pushExp(1, 8'h07, 1'b1, 1'b0, 1'b0);
    send(1, 8'h07);
    waitIdle(1);
    pushExp(2, 8'h07, 1'b0, 1'b0, 1'b0);
    send(2, 8'h07);
    waitIdle(2);

    // two stop bits
    pushExp(3, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(3, 8'hFF);
    waitIdle(3);

    // reset during data bit 3
    pushExp(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send(0, 8'h3C);
    repeat (70) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    chk("t7_tx_async", 32'(txV[0]), 32'd1);
    chk("t7_busy_async", 32'(busyV[0]), 32'd0);
    chk("t7_ready_async", 32'(readyV), 32'hF);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (txV !== 4'hF || busyV !== 4'h0 || doneV !== 4'h0) quiet = 1'b0;
    end
    chk("t7_quiet_after_release", 32'(quiet), 32'd1);

    repeat (5) @(negedge clk);
    chk("q0_left", q0.size(), 32'd0);
    chk("q1_left", q1.size(), 32'd0);
    chk("q2_left", q2.size(), 32'd0);
    chk("q3_left", q3.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
